ps2_tx: RTL and testbench

- PS/2 host-to-device transmitter. It is the send side of the existing keyboard receiver (kb).
- Sends command bytes to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset).
- Runs on clock_25 beside kb. The top level turns the oe outputs into open-drain drives: PS2_CLK = clk_oe ? 0 : Z, and likewise for PS2_DAT.
- busy is routed to kb so the receiver ignores the clock edges of our own transmissions.

---
 rtl/ps2_tx_pkg.sv | 31 +++
 rtl/ps2_sync.sv | 78 +++++++
 rtl/ps2_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_tx.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg: shared definitions for the PS/2 host transmitter and its
// line synchronizer.
//   - state_t      : transmitter FSM state encoding
//   - RTS_HOLD     : cycles both lines are held low after the inhibit period
//   - FILT_LEN     : cycles a new CLK level must persist (PS2_TX_FILTER_EN)
//   - CMD_*        : common AT keyboard command bytes
//   - odd_parity() : parity bit that makes the 9-bit data+parity group odd
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_RTS     = 3'd2,
    ST_DATA    = 3'd3,
    ST_ACK     = 3'd4,
    ST_WAITREL = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  localparam int RTS_HOLD = 16;
  localparam int FILT_LEN = 8;

  localparam logic [7:0] CMD_LED    = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: brings the raw PS/2 CLK and DAT lines into the clock domain and
// flags CLK falling edges. Shared with the keyboard receiver.
// Optional macro PS2_TX_FILTER_EN: when defined, the synchronized CLK must
// hold a new level for FILT_LEN consecutive cycles before it is accepted,
// which rejects short glitches at the cost of FILT_LEN cycles of latency.
// Ports:
//   clock   in  system clock
//   reset_n in  synchronous active-low reset
//   ps_clk  in  raw PS/2 CLK line
//   ps_dat  in  raw PS/2 DAT line
//   clk_s   out synchronized (optionally filtered) CLK level
//   dat_s   out synchronized DAT level
//   fall    out one-cycle strobe on a CLK high-to-low transition
module ps2_sync
  import ps2_tx_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic ps_clk,
  input  logic ps_dat,
  output logic clk_s,
  output logic dat_s,
  output logic fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_lvl;
  logic       clk_prev;

  // Idle bus is high, so reset the flops to 1 to avoid a fake edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_ff <= 2'b11;
      dat_ff <= 2'b11;
    end else begin
      clk_ff <= {clk_ff[0], ps_clk};
      dat_ff <= {dat_ff[0], ps_dat};
    end
  end

`ifdef PS2_TX_FILTER_EN
  localparam int CW = $clog2(FILT_LEN);

  logic [CW-1:0] filt_cnt;
  logic          clk_filt;

  // Count consecutive cycles that disagree with the accepted level; any
  // agreeing cycle restarts the count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_ff[1] == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == CW'(FILT_LEN - 1)) begin
      clk_filt <= clk_ff[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign clk_lvl = clk_filt;
`else
  assign clk_lvl = clk_ff[1];
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) clk_prev <= 1'b1;
    else          clk_prev <= clk_lvl;
  end

  assign fall  = clk_prev & ~clk_lvl;
  assign clk_s = clk_lvl;
  assign dat_s = dat_ff[1];

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device transmitter. Inhibits the bus, issues a
// request-to-send, then shifts one byte out on device-generated clocks and
// checks the device ACK. The oe outputs drive open-drain pads (1 = pull low).
// Optional macro PS2_TX_FILTER_EN (see ps2_sync) adds a CLK glitch filter.
// Ports:
//   clock   in  system clock
//   reset_n in  synchronous active-low reset
//   ps_clk  in  raw PS/2 CLK line
//   ps_dat  in  raw PS/2 DAT line
//   data    in  byte to send, captured when send is accepted
//   send    in  request pulse, honoured only when idle
//   clk_oe  out pull CLK low
//   dat_oe  out pull DAT low
//   busy    out transfer in progress
//   done    out one-cycle pulse: byte sent and acknowledged
//   err     out one-cycle pulse: timeout or missing ACK
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | bus released, waiting for send
// ST_INHIBIT | CLK held low for INH cycles
// ST_RTS     | CLK and DAT (start bit) low for RTS_HOLD cycles
// ST_DATA    | CLK released; next frame bit driven on each device fall
// ST_ACK     | waiting for fall 11, DAT must be low (device ACK)
// ST_WAITREL | waiting for device to release CLK and DAT
// ST_FAIL    | release both lines, pulse err
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps_clk,
  input  logic       ps_dat,
  input  logic [7:0] data,
  input  logic       send,
  output logic       clk_oe,
  output logic       dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH     = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TMO     = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int TMR_MAX = (TMO > INH) ? TMO : INH;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INH - 1);
  localparam logic [TMR_W-1:0] RTS_LAST = TMR_W'(RTS_HOLD - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [3:0]       bitcnt;
  // {stop, parity, data[7:0]}; the start bit is driven directly in RTS.
  logic [9:0]       shreg;
  logic             clk_s;
  logic             dat_s;
  logic             fall;
  logic             tmo_hit;

  ps2_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .ps_clk  (ps_clk),
    .ps_dat  (ps_dat),
    .clk_s   (clk_s),
    .dat_s   (dat_s),
    .fall    (fall)
  );

  assign tmo_hit = (timer == TMO_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      clk_oe <= 1'b0;
      dat_oe <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      timer  <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (send) begin
            shreg  <= {1'b1, odd_parity(data), data};
            busy   <= 1'b1;
            clk_oe <= 1'b1;
            timer  <= '0;
            state  <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (timer == INH_LAST) begin
            dat_oe <= 1'b1;
            timer  <= '0;
            state  <= ST_RTS;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_RTS: begin
          if (timer == RTS_LAST) begin
            clk_oe <= 1'b0;
            timer  <= '0;
            bitcnt <= '0;
            state  <= ST_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // A fall in the same cycle as the timeout takes priority.
        ST_DATA: begin
          if (fall) begin
            dat_oe <= ~shreg[0];
            shreg  <= {1'b0, shreg[9:1]};
            timer  <= '0;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 4'd9) state <= ST_ACK;
          end else if (tmo_hit) begin
            state <= ST_FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_ACK: begin
          if (fall) begin
            timer <= '0;
            state <= dat_s ? ST_FAIL : ST_WAITREL;
          end else if (tmo_hit) begin
            state <= ST_FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_WAITREL: begin
          if (clk_s && dat_s) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (tmo_hit) begin
            state <= ST_FAIL;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_FAIL: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          err    <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: self-checking bench for ps2_tx. A behavioural PS/2 device model
// generates clocks, samples DAT on each rising edge and optionally ACKs.
// Timing parameters are scaled down so every scenario completes quickly.
module tb_ps2_tx;

  localparam int CLK_HZ     = 2000000;
  localparam int INHIBIT_US = 10;
  localparam int TIMEOUT_MS = 1;
  localparam int INH        = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TMO        = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int RTS_LEN    = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       send = 1'b0;
  logic [7:0] data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps_clk, ps_dat;
  logic       clk_oe, dat_oe, busy, done, err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Open-drain bus with pull-ups.
  assign ps_clk = ~(clk_oe | dev_clk_low);
  assign ps_dat = ~(dat_oe | dev_dat_low);

  ps2_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ps_clk  (ps_clk),
    .ps_dat  (ps_dat),
    .data    (data),
    .send    (send),
    .clk_oe  (clk_oe),
    .dat_oe  (dat_oe),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9] = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    @(negedge clock);
    data = d;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    data = 8'($urandom);
  endtask

  // Device model: waits for the host to release CLK, then generates nclk
  // clocks. bits[0] is DAT before the first clock, bits[k] is DAT at the
  // rising edge of clock k. On clock 11 DAT is pulled low when ack is set.
  task automatic run_device(input int nclk, input logic ack,
                            output logic [10:0] bits, output logic ok);
    int h, n;
    h = int'($urandom_range(20, 40));
    bits = '1;
    ok = 1'b1;
    n = 0;
    while (clk_oe !== 1'b0 && n < INH + RTS_LEN + 100) begin
      @(negedge clock);
      n++;
    end
    if (clk_oe !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    bits[0] = ps_dat;
    for (int k = 1; k <= nclk; k++) begin
      repeat (h) @(negedge clock);
      if (k == 11) begin
        dev_dat_low = ack;
        repeat (4) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (h) @(negedge clock);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = ps_dat;
    end
    if (nclk >= 11) begin
      repeat (h) @(negedge clock);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_result(input int d0, input int e0, output logic ok);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    ok = (done_cnt != d0 || err_cnt != e0);
    repeat (5) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({clk_oe, dat_oe, busy, done, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {clk_oe, dat_oe, busy, done, err});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=000", {clk_oe, dat_oe, busy});
    end
  endtask

  task automatic test_rts_timing();
    int clk_high, pre_dat, busy_bad, guard, d0, e0;
    logic [10:0] bits;
    logic ok;
    d0 = done_cnt;
    e0 = err_cnt;
    clk_high = 0;
    pre_dat = 0;
    busy_bad = 0;
    guard = 0;
    send_byte(8'hF4);
    while (clk_oe === 1'b1 && guard < INH + RTS_LEN + 100) begin
      clk_high++;
      if (dat_oe !== 1'b1) pre_dat++;
      if (busy !== 1'b1) busy_bad++;
      @(negedge clock);
      guard++;
    end
    checks++;
    if (clk_high != INH + RTS_LEN) begin
      failures++;
      $display("FAIL rts_clk_low_cycles got=%0d exp=%0d", clk_high, INH + RTS_LEN);
    end
    checks++;
    if (pre_dat != INH) begin
      failures++;
      $display("FAIL rts_dat_delay got=%0d exp=%0d", pre_dat, INH);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL rts_busy low_cycles=%0d exp=0", busy_bad);
    end
    run_device(11, 1'b1, bits, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL rts_device_wait got=timeout exp=clk_release");
    end
    checks++;
    if (bits !== exp_frame(8'hF4)) begin
      failures++;
      $display("FAIL frame_F4 got=%b exp=%b", bits, exp_frame(8'hF4));
    end
    wait_result(d0, e0, ok);
    checks++;
    if (done_cnt != d0 + 1 || err_cnt != e0) begin
      failures++;
      $display("FAIL f4_result done=%0d err=%0d exp done=1 err=0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b0) begin
      failures++;
      $display("FAIL f4_release got=%b exp=000", {clk_oe, dat_oe, busy});
    end
  endtask

  task automatic test_parity_frames();
    logic [7:0] pv [4];
    logic       pp [4];
    logic [7:0] d;
    logic [10:0] bits;
    logic ok;
    int d0, e0;
    pv[0] = 8'hED; pp[0] = 1'b1;
    pv[1] = 8'h00; pp[1] = 1'b1;
    pv[2] = 8'hFF; pp[2] = 1'b1;
    pv[3] = 8'h01; pp[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = (i < 4) ? pv[i] : 8'($urandom);
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(d);
      run_device(11, 1'b1, bits, ok);
      checks++;
      if (ok !== 1'b1 || bits !== exp_frame(d)) begin
        failures++;
        $display("FAIL frame_%02h got=%b exp=%b", d, bits, exp_frame(d));
      end
      if (i < 4) begin
        checks++;
        if (bits[9] !== pp[i]) begin
          failures++;
          $display("FAIL parity_%02h got=%b exp=%b", d, bits[9], pp[i]);
        end
      end
      wait_result(d0, e0, ok);
      checks++;
      if (done_cnt != d0 + 1 || err_cnt != e0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_%02h done=%0d err=%0d busy=%b exp 1 0 0", d, done_cnt - d0, err_cnt - e0, busy);
      end
    end
  endtask

  task automatic test_missing_ack();
    logic [7:0] d;
    logic [10:0] bits;
    logic ok;
    int d0, e0;
    d = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(d);
    run_device(11, 1'b0, bits, ok);
    checks++;
    if (ok !== 1'b1 || bits !== exp_frame(d)) begin
      failures++;
      $display("FAIL noack_frame got=%b exp=%b", bits, exp_frame(d));
    end
    wait_result(d0, e0, ok);
    checks++;
    if (err_cnt != e0 + 1 || done_cnt != d0) begin
      failures++;
      $display("FAIL noack_result done=%0d err=%0d exp done=0 err=1", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b0) begin
      failures++;
      $display("FAIL noack_release got=%b exp=000", {clk_oe, dat_oe, busy});
    end
  endtask

  task automatic test_timeout();
    int n, d0;
    d0 = done_cnt;
    send_byte(8'hFF);
    n = 0;
    while (clk_oe !== 1'b0 && n < INH + RTS_LEN + 100) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (err !== 1'b1 && n < TMO + 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (err !== 1'b1 || n < TMO - 2 || n > TMO + 2) begin
      failures++;
      $display("FAIL timeout_delay got=%0d exp=%0d+-2", n, TMO);
    end
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL timeout_release got=%b done=%0d exp=000 done=0", {clk_oe, dat_oe, busy}, done_cnt - d0);
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic test_reset_midframe();
    logic [10:0] bits;
    logic ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hF0);
    run_device(4, 1'b1, bits, ok);
    repeat (3) @(negedge clock);
    checks++;
    if (ok !== 1'b1 || dat_oe !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midframe_state dat_oe=%b busy=%b exp 1 1", dat_oe, busy);
    end
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b0) begin
      failures++;
      $display("FAIL midframe_reset got=%b exp=000", {clk_oe, dat_oe, busy});
    end
    reset_n = 1'b1;
    repeat (TMO / 4) @(negedge clock);
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      failures++;
      $display("FAIL midframe_pulses done=%0d err=%0d exp 0 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [10:0] bits;
    logic ok;
    int d0, e0, extra;
    a = 8'($urandom);
    b = a ^ 8'h5A;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(a);
    repeat (3) @(negedge clock);
    send_byte(b);
    run_device(11, 1'b1, bits, ok);
    checks++;
    if (ok !== 1'b1 || bits !== exp_frame(a)) begin
      failures++;
      $display("FAIL b2b_frame got=%b exp=%b", bits, exp_frame(a));
    end
    wait_result(d0, e0, ok);
    extra = 0;
    repeat (INH * 4) begin
      @(negedge clock);
      if (clk_oe === 1'b1) extra++;
    end
    checks++;
    if (done_cnt != d0 + 1 || err_cnt != e0 || extra != 0) begin
      failures++;
      $display("FAIL b2b_single done=%0d err=%0d second_frame_cycles=%0d exp 1 0 0", done_cnt - d0, err_cnt - e0, extra);
    end
  endtask

  initial begin
    test_reset();
    test_rts_timing();
    test_parity_frames();
    test_missing_ack();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL done_err_overlap got=%0d exp=0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
